// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with staging/shadow double buffering.
// Optional blink gating is compiled in with `define BCD_SEG_SCAN_BLINK_EN.
module bcd_seg_scan #(
    parameter int DIV_CNT  = 50000,
    parameter int LZ_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_hi,
    input  logic [7:0] bcd_lo,
    input  logic       load,
    input  logic [3:0] dp_mask,
`ifdef BCD_SEG_SCAN_BLINK_EN
    input  logic       blink,
`endif
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int                CNT_W   = $clog2(DIV_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV_CNT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_armed;
    logic [15:0]      r_stage_bcd;
    logic [3:0]       r_stage_dp;
    logic             r_pending;
    logic [15:0]      r_shadow_bcd;
    logic [3:0]       r_shadow_dp;
    logic [7:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_boundary;
    logic             w_dark;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [7:0]       w_seg_nxt;
    logic [3:0]       w_an_nxt;

    function automatic logic [6:0] f_seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_boundary = w_tick && r_armed && (r_idx == 2'd3);

    // The first slot after reset is dark (r_armed low) so digit 0 always gets a full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_armed <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (r_armed) begin
                r_idx <= r_idx + 2'd1;
            end else begin
                r_armed <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_bcd <= '0;
            r_stage_dp  <= '0;
        end else if (load) begin
            r_stage_bcd <= {bcd_hi, bcd_lo};
            r_stage_dp  <= dp_mask;
        end
    end

    // A load coinciding with the boundary bypasses staging straight into the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
        end else if (w_boundary && load) begin
            r_pending    <= 1'b0;
            r_shadow_bcd <= {bcd_hi, bcd_lo};
            r_shadow_dp  <= dp_mask;
        end else if (w_boundary && r_pending) begin
            r_pending    <= 1'b0;
            r_shadow_bcd <= r_stage_bcd;
            r_shadow_dp  <= r_stage_dp;
        end else if (load) begin
            r_pending <= 1'b1;
        end
    end

`ifdef BCD_SEG_SCAN_BLINK_EN
    logic [5:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_boundary) begin
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    assign w_dark = blink & r_frame_cnt[5];
`else
    assign w_dark = 1'b0;
`endif

    always_comb begin
        w_nib = 4'd0;
        case (r_idx)
            2'd0: w_nib = r_shadow_bcd[3:0];
            2'd1: w_nib = r_shadow_bcd[7:4];
            2'd2: w_nib = r_shadow_bcd[11:8];
            2'd3: w_nib = r_shadow_bcd[15:12];
            default: w_nib = 4'd0;
        endcase
    end

    // Tens digits sit at odd indices; only those are candidates for blanking.
    assign w_blank = (LZ_BLANK != 0) && r_idx[0] && (w_nib == 4'd0);

    always_comb begin
        w_seg_nxt = 8'hFF;
        w_an_nxt  = 4'hF;
        if (r_armed && !w_tick && !w_dark) begin
            w_an_nxt     = ~(4'b0001 << r_idx);
            w_seg_nxt[7] = ~r_shadow_dp[r_idx];
            w_seg_nxt[6:0] = w_blank ? 7'h7F : f_seg_decode(w_nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= 8'hFF;
            r_an         <= 4'hF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
